softmax_row_sequencer: RTL and testbench
========================================

Name: softmax_row_sequencer

Overview:
Front-end and back-end controller for the softmax max-finding stage.
- Collects one row of ARRAYWIDTH signed scores from the output-buffer stream (valid/ready).
- Presents the row in parallel to the systolic odd-even sorter with a one-cycle enable, then waits a fixed sort latency.
- Captures the row maximum and streams each element back minus that maximum, for the downstream exp stage.
- Sits between the output buffer and the exp/normalise pipeline; the parent module instantiates the sorter.

Parameters:
ARRAYWIDTH, `ARRAYWIDTH, elements per row; even, >=2
DW, `OUTPUT_BUF_DATASIZE, element width, signed two's complement
SORT_LATENCY, `ARRAYWIDTH+2, cycles from the sort_en pulse until sort_max is valid; >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input element valid
in_ready  out  1  block accepts an element this cycle
in_data  in  DW  input element, signed
sort_en  out  1  one-cycle start pulse to the sorter
sort_data  out  ARRAYWIDTH*DW  packed row; lane i at [i*DW +: DW], lane 0 = first accepted element
sort_max  in  DW  row maximum from the sorter
out_valid  out  1  output element valid
out_ready  in  1  downstream accepts
out_data  out  DW+1  element minus row max, signed
out_last  out  1  marks the final element of the row
row_max  out  DW  captured maximum, held for the row
busy  out  1  high in any state other than COLLECT

Behaviour:
- States and transitions:
  - COLLECT: in_ready=1. On in_valid&&in_ready, write in_data to lane cidx and increment cidx. Accepting cidx==ARRAYWIDTH-1 moves to FIRE.
  - FIRE: one cycle. sort_en=1. Clear wcnt. Go to WAIT.
  - WAIT: increment wcnt each cycle. When wcnt==SORT_LATENCY-1, register sort_max into row_max, clear eidx, go to EMIT.
  - EMIT: out_valid=1. out_data = sext(lane[eidx]) - sext(row_max), computed in DW+1 bits with no saturation. out_last = (eidx==ARRAYWIDTH-1). On out_valid&&out_ready, increment eidx. The handshake with out_last high clears cidx and returns to COLLECT.
- Timing: last input accepted at edge T -> sort_en high in cycle T+1 -> sort_max sampled at end of cycle T+1+SORT_LATENCY -> out_valid high from cycle T+2+SORT_LATENCY.
- sort_data is driven directly from the lane registers. It is stable from FIRE through the end of EMIT, because no writes occur outside COLLECT.
- in_ready=0 outside COLLECT. in_valid there is ignored and no data is consumed.
- Backpressure: while out_valid&&!out_ready, out_data, out_last and eidx hold. An unbounded stall is legal.
- Back-to-back rows: COLLECT is re-entered in the cycle after the last output handshake. No bubble beyond the state change.
- sort_max is sampled exactly once per row. Its value at any other time is don't-care.
- Reset (asynchronous, any state): state=COLLECT; cidx, eidx, wcnt, row_max and all lanes cleared.
  - Outputs during and after reset: sort_en=0, out_valid=0, out_last=0, busy=0, out_data=0.
  - in_ready=0 while rst is high, 1 in the first cycle after release.
  - A partial row or an in-flight sort is discarded.
- Counter widths: cidx and eidx use $clog2(ARRAYWIDTH); wcnt uses $clog2(SORT_LATENCY+1). None wraps in normal operation.

Decomposition:
- State encodings (COLLECT, FIRE, WAIT, EMIT) go in a shared softmax header alongside config.v, so the future exp/normalise controller can reuse them.
- ARRAYWIDTH and DW defaults come from config.v.
- One natural sub-module: softmax_row_buffer, the ARRAYWIDTH x DW lane register file with indexed write, indexed read and a packed parallel view.
- FSM and counters stay in this module. The sorter is not instantiated here.

Test Plan:
All scenarios use ARRAYWIDTH=4, DW=16, SORT_LATENCY=6, with a behavioural sorter stub returning the lane maximum after 6 cycles.
1. Row 3,-1,7,2 with out_ready=1 -> sort_en high exactly one cycle (T+1); sort_data=0x0002_0007_FFFF_0003; outputs -4,-8,0,-5 starting at T+8; out_last only on -5; row_max=7.
2. Row 10,20,30,40 with out_ready low for 3 cycles at the second element -> out_data holds -20 throughout the stall; outputs -30,-20,-10,0; no element lost or duplicated.
3. Row -32768,32767,0,0 -> out_data 17-bit -65535, 0, -32767, -32767; no wrap.
4. in_valid held high during FIRE, WAIT and EMIT with values 99 -> in_ready=0 throughout; next row's first lane takes the first value offered after return to COLLECT.
5. rst pulsed mid-WAIT -> sort_en, out_valid and busy go 0 immediately; a subsequent row 1,2,3,4 yields -3,-2,-1,0 correctly.
6. Two rows streamed with in_valid and out_ready constantly high -> second row's first accept occurs the cycle after the first row's out_last handshake; both rows are correct.

Source files
------------

// File: rtl/softmax_row_sequencer_pkg.sv
// Shared softmax definitions: controller state encodings and default row geometry,
// reused by the row sequencer and the exp/normalise controller.
package softmax_row_sequencer_pkg;

    localparam int DEFAULT_ARRAYWIDTH = 4;
    localparam int DEFAULT_DW         = 16;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FIRE    = 2'd1,
        WAIT    = 2'd2,
        EMIT    = 2'd3
    } softmax_state_e;

    // The sorter needs one cycle per lane plus two for load and drain.
    function automatic int default_sort_latency(input int arraywidth);
        return arraywidth + 2;
    endfunction

endpackage

// File: rtl/softmax_row_buffer.sv
// Lane register file for one softmax row: indexed write, indexed read and a
// packed parallel view of all lanes for the sorter.
module softmax_row_buffer
    import softmax_row_sequencer_pkg::*;
#(
    parameter int ARRAYWIDTH = DEFAULT_ARRAYWIDTH,
    parameter int DW         = DEFAULT_DW,
    localparam int IW        = $clog2(ARRAYWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [IW-1:0]            i_wr_idx,
    input  logic [DW-1:0]            i_wr_data,
    input  logic [IW-1:0]            i_rd_idx,
    output logic [DW-1:0]            o_rd_data,
    output logic [ARRAYWIDTH*DW-1:0] o_packed
);

    logic [DW-1:0] r_lanes [ARRAYWIDTH];

    // NOTE: the lanes are small flops, not RAM, so they take the reset; that keeps
    // the packed view deterministic after a discarded partial row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARRAYWIDTH; i++) begin
                r_lanes[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_lanes[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_lanes[i_rd_idx];

    for (genvar g = 0; g < ARRAYWIDTH; g++) begin : g_pack
        assign o_packed[g*DW +: DW] = r_lanes[g];
    end

endmodule

// File: rtl/softmax_row_sequencer.sv
// Softmax max-finding controller: gathers a row, launches the external sorter,
// captures the row maximum and streams each element minus that maximum.
module softmax_row_sequencer
    import softmax_row_sequencer_pkg::*;
#(
    parameter int ARRAYWIDTH   = DEFAULT_ARRAYWIDTH,
    parameter int DW           = DEFAULT_DW,
    parameter int SORT_LATENCY = default_sort_latency(ARRAYWIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     sort_en,
    output logic [ARRAYWIDTH*DW-1:0] sort_data,
    input  logic [DW-1:0]            sort_max,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW:0]              out_data,
    output logic                     out_last,
    output logic [DW-1:0]            row_max,
    output logic                     busy
);

    localparam int IW = $clog2(ARRAYWIDTH);
    localparam int WW = $clog2(SORT_LATENCY + 1);

    softmax_state_e r_state, w_state_next;
    logic [IW-1:0]  r_cidx, r_eidx;
    logic [WW-1:0]  r_wcnt;
    logic [DW-1:0]  r_row_max;
    logic [DW-1:0]  w_rd_data;
    logic [DW:0]    w_diff;
    logic           w_in_fire, w_out_fire;
    logic           w_cidx_last, w_eidx_last, w_wait_done;

    assign w_cidx_last = (r_cidx == IW'(ARRAYWIDTH - 1));
    assign w_eidx_last = (r_eidx == IW'(ARRAYWIDTH - 1));
    assign w_wait_done = (r_wcnt == WW'(SORT_LATENCY - 1));

    // Held low through reset so nothing is consumed before the FSM is live.
    assign in_ready   = (r_state == COLLECT) && !rst;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign busy       = (r_state != COLLECT);
    assign row_max    = r_row_max;

    softmax_row_buffer #(
        .ARRAYWIDTH (ARRAYWIDTH),
        .DW         (DW)
    ) u_row_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_in_fire),
        .i_wr_idx  (r_cidx),
        .i_wr_data (in_data),
        .i_rd_idx  (r_eidx),
        .o_rd_data (w_rd_data),
        .o_packed  (sort_data)
    );

    // One extra bit makes the subtraction exact across the full signed range.
    assign w_diff   = $signed({w_rd_data[DW-1], w_rd_data}) - $signed({r_row_max[DW-1], r_row_max});
    assign out_data = out_valid ? w_diff : '0;

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= COLLECT;
            r_cidx    <= '0;
            r_eidx    <= '0;
            r_wcnt    <= '0;
            r_row_max <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                COLLECT: if (w_in_fire) r_cidx <= w_cidx_last ? '0 : r_cidx + 1'b1;
                FIRE:    r_wcnt <= '0;
                WAIT: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (w_wait_done) begin
                        r_row_max <= sort_max;
                        r_eidx    <= '0;
                    end
                end
                EMIT: begin
                    if (w_out_fire) begin
                        r_eidx <= w_eidx_last ? '0 : r_eidx + 1'b1;
                        if (w_eidx_last) r_cidx <= '0;
                    end
                end
                default: r_cidx <= '0;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        sort_en      = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        unique case (r_state)
            COLLECT: if (w_in_fire && w_cidx_last) w_state_next = FIRE;
            FIRE: begin
                sort_en      = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: if (w_wait_done) w_state_next = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                out_last  = w_eidx_last;
                if (out_ready && w_eidx_last) w_state_next = COLLECT;
            end
            default: w_state_next = COLLECT;
        endcase
    end

endmodule

// File: tb/tb_softmax_row_sequencer.sv
// Directed bench for softmax_row_sequencer with a behavioural sorter stub that
// returns the lane maximum six cycles after its start pulse.
module tb_softmax_row_sequencer;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int SL = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            sort_en;
    logic [AW*DW-1:0] sort_data;
    logic [DW-1:0]   sort_max;
    logic            out_valid;
    logic            out_ready;
    logic [DW:0]     out_data;
    logic            out_last;
    logic [DW-1:0]   row_max;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int t_first_acc, t_last_acc, t_first_valid, t_last_hs;

    softmax_row_sequencer #(
        .ARRAYWIDTH   (AW),
        .DW           (DW),
        .SORT_LATENCY (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sort_en   (sort_en),
        .sort_data (sort_data),
        .sort_max  (sort_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .row_max   (row_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] max4(input logic [AW*DW-1:0] r);
        logic signed [DW-1:0] m;
        logic signed [DW-1:0] v;
        m = r[DW-1:0];
        for (int i = 1; i < AW; i++) begin
            v = r[i*DW +: DW];
            if (v > m) m = v;
        end
        return m;
    endfunction

    // Sorter stub: sort_max is garbage until SL cycles after the start pulse.
    int            st_cnt = 0;
    logic [DW-1:0] st_max = '0;
    always @(posedge clk) begin
        if (sort_en) begin
            st_cnt <= 1;
            st_max <= max4(sort_data);
        end else if (st_cnt != 0 && st_cnt < SL) begin
            st_cnt <= st_cnt + 1;
        end
    end
    assign sort_max = (st_cnt >= SL) ? st_max : 16'h5A5A;

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    endtask

    function automatic logic [AW*DW-1:0] row4(input int a, input int b, input int c, input int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic logic [AW*(DW+1)-1:0] exp4(input int a, input int b, input int c, input int d);
        return {d[DW:0], c[DW:0], b[DW:0], a[DW:0]};
    endfunction

    // Called at a negedge; returns at the negedge after the last accepting edge.
    task automatic send_row(input logic [AW*DW-1:0] r);
        int   i = 0;
        int   g = 0;
        logic acc;
        in_valid = 1'b1;
        in_data  = r[DW-1:0];
        while (i < AW && g < 200) begin
            acc = in_ready;
            @(negedge clk);
            g++;
            if (acc) begin
                if (i == 0) t_first_acc = cyc;
                t_last_acc = cyc;
                i++;
                if (i < AW) in_data = r[i*DW +: DW];
            end
        end
        in_valid = 1'b0;
        check("send_accepts", i, AW);
    endtask

    task automatic recv_row(input logic [AW*(DW+1)-1:0] e, input int stall_k, input int stall_n,
                            input string nm);
        int g = 0;
        out_ready = 1'b1;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({nm, "_valid_seen"}, longint'(out_valid), 1);
        t_first_valid = cyc;
        for (int k = 0; k < AW; k++) begin
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check({nm, "_stall_data"}, longint'($signed(out_data)), longint'($signed(e[k*(DW+1) +: DW+1])));
                    check({nm, "_stall_valid"}, longint'(out_valid), 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            check({nm, "_valid"}, longint'(out_valid), 1);
            check({nm, "_data"}, longint'($signed(out_data)), longint'($signed(e[k*(DW+1) +: DW+1])));
            check({nm, "_last"}, longint'(out_last), (k == AW - 1) ? 1 : 0);
            @(negedge clk);
        end
        t_last_hs = cyc;
        check({nm, "_idle_after"}, longint'(out_valid), 0);
    endtask

    initial begin
        int  t_acc, hs1, fa2, viol, samples;
        logic done;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_sort_en", longint'(sort_en), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_row_max", longint'(row_max), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);

        // 1: basic row, latency and sort handoff
        send_row(row4(3, -1, 7, 2));
        t_acc = t_last_acc;
        check("t1_sort_en_on", longint'(sort_en), 1);
        check("t1_sort_data", longint'(sort_data), 64'h0002_0007_FFFF_0003);
        check("t1_busy", longint'(busy), 1);
        check("t1_in_ready_fire", longint'(in_ready), 0);
        @(negedge clk);
        check("t1_sort_en_off", longint'(sort_en), 0);
        recv_row(exp4(-4, -8, 0, -5), -1, 0, "t1");
        check("t1_latency", t_first_valid - t_acc, 7);
        check("t1_row_max", longint'($signed(row_max)), 7);

        // 2: backpressure on the second element
        send_row(row4(10, 20, 30, 40));
        recv_row(exp4(-30, -20, -10, 0), 1, 3, "t2");
        check("t2_row_max", longint'($signed(row_max)), 40);

        // 3: full-range operands
        send_row(row4(-32768, 32767, 0, 0));
        recv_row(exp4(-65535, 0, -32767, -32767), -1, 0, "t3");
        check("t3_row_max", longint'($signed(row_max)), 32767);

        // 4: input offered while busy is ignored
        send_row(row4(1, 1, 1, 1));
        in_valid = 1'b1;
        in_data  = 16'd99;
        done     = 1'b0;
        viol     = 0;
        samples  = 0;
        fork
            begin
                recv_row(exp4(0, 0, 0, 0), -1, 0, "t4a");
                done = 1'b1;
            end
            begin
                while (!done && samples < 200) begin
                    if (busy && in_ready) viol++;
                    samples++;
                    @(negedge clk);
                end
            end
        join
        check("t4_in_ready_blocked", viol, 0);
        send_row(row4(5, 1, 2, 3));
        recv_row(exp4(0, -4, -3, -2), -1, 0, "t4b");

        // 5: reset in the middle of the sort wait
        send_row(row4(9, 8, 7, 6));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_sort_en", longint'(sort_en), 0);
        check("t5_out_valid", longint'(out_valid), 0);
        check("t5_busy", longint'(busy), 0);
        check("t5_in_ready", longint'(in_ready), 0);
        check("t5_row_max", longint'(row_max), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_in_ready_rel", longint'(in_ready), 1);
        send_row(row4(1, 2, 3, 4));
        recv_row(exp4(-3, -2, -1, 0), -1, 0, "t5");

        // 6: back-to-back rows with continuous valid/ready
        fork
            begin
                send_row(row4(-5, -9, -2, -7));
                send_row(row4(100, -100, 50, 0));
                fa2 = t_first_acc;
            end
            begin
                recv_row(exp4(-3, -7, 0, -5), -1, 0, "t6a");
                hs1 = t_last_hs;
                recv_row(exp4(0, -200, -50, -100), -1, 0, "t6b");
            end
        join
        check("t6_no_bubble", fa2 - hs1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
